// File: rtl/imem_loader.sv
// imem_loader: unpacks a length-prefixed big-endian byte stream into 32-bit instruction memory writes.
// Holds the core in reset-like hold while a program image is being loaded.
module imem_loader #(
    parameter int DEPTH = 1025,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic          cpu_hold,
    output logic          done,
    output logic          error,
    output logic [15:0]   words_wr
);
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR} state_t;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);
    state_t state, state_nx;
    logic [7:0] n_hi;
    logic [15:0] n;
    logic [23:0] asm_q;
    logic [1:0] cnt;
    logic xfer, idle_like;
    logic [15:0] hdr;
    assign xfer = in_valid & in_ready;
    assign hdr = {n_hi, in_data};
    assign idle_like = (state == IDLE) || (state == DONE) || (state == ERR);
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        wr_en = 1'b0;
        done = 1'b0;
        error = 1'b0;
        cpu_hold = 1'b0;
        case (state)
            IDLE, DONE, ERR: state_nx = start ? LEN_HI : state;
            LEN_HI: state_nx = xfer ? LEN_LO : LEN_HI;
            LEN_LO: state_nx = !xfer ? LEN_LO : (hdr == 16'd0) ? DONE : ({1'b0, hdr} > DEPTH_W) ? ERR : DATA;
            DATA: state_nx = (xfer && cnt == 2'd3) ? WRITE : DATA;
            WRITE: state_nx = (words_wr + 16'd1 == n) ? DONE : DATA;
            default: state_nx = IDLE;
        endcase
        in_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
        wr_en = state == WRITE;
        done = state == DONE;
        error = state == ERR;
        cpu_hold = !idle_like;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            n_hi <= '0;
            n <= '0;
            asm_q <= '0;
            cnt <= '0;
            words_wr <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state <= state_nx;
            if (idle_like && start) begin
                words_wr <= '0;
                wr_addr <= '0;
                cnt <= '0;
            end
            if (state == LEN_HI && xfer) n_hi <= in_data;
            if (state == LEN_LO && xfer) n <= hdr;
            // The write port is loaded as the 4th byte lands so it is valid during WRITE.
            if (state == DATA && xfer) begin
                asm_q <= {asm_q[15:0], in_data};
                cnt <= cnt + 2'd1;
                if (cnt == 2'd3) begin
                    wr_addr <= AW'(words_wr);
                    wr_data <= {asm_q, in_data};
                end
            end
            if (state == WRITE) begin
                words_wr <= words_wr + 16'd1;
                cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of image loading, empty/oversize headers, stalls, reset abort and restart.
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset, start, in_valid, in_ready, wr_en, cpu_hold, done, error;
    logic [7:0] in_data;
    logic [31:0] wr_addr, wr_data;
    logic [15:0] words_wr;
    int total = 0;
    int bad = 0;
    int nacc = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [7:0] img [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h04};

    always #5 clk = ~clk;

    imem_loader dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .error(error), .words_wr(words_wr)
    );

    always @(negedge clk) begin
        if (wr_en) begin
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
        end
        if (in_valid && in_ready) nacc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        wa.delete();
        wd.delete();
        nacc = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit rnd);
        int t = 0;
        if (rnd) begin
            in_valid = 1'b0;
            tick($urandom_range(0, 2));
        end
        in_data = b;
        in_valid = 1'b1;
        while (!in_ready) begin
            tick();
            t++;
            if (t > 100) begin
                total++;
                bad++;
                $error("FAIL send_timeout: observed=in_ready_low expected=accept_within_100");
                in_valid = 1'b0;
                return;
            end
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_img(input bit rnd, input int poke);
        for (int i = 0; i < 10; i++) begin
            if (i == poke) begin
                in_valid = 1'b0;
                pulse_start();
            end
            send(img[i], rnd);
        end
        tick();
    endtask

    task automatic check_img(input string tag);
        chk({tag, "_npulse"}, wa.size(), 2);
        chk({tag, "_a0"}, wa.size() > 0 ? wa[0] : 'x, 32'd0);
        chk({tag, "_d0"}, wd.size() > 0 ? wd[0] : 'x, 32'h20080005);
        chk({tag, "_a1"}, wa.size() > 1 ? wa[1] : 'x, 32'd1);
        chk({tag, "_d1"}, wd.size() > 1 ? wd[1] : 'x, 32'hAC080004);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_hold"}, cpu_hold, 0);
        chk({tag, "_words"}, words_wr, 2);
        chk({tag, "_nacc"}, nacc, 10);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rdy"}, in_ready, 0);
        chk({tag, "_wen"}, wr_en, 0);
        chk({tag, "_addr"}, wr_addr, 0);
        chk({tag, "_data"}, wr_data, 0);
        chk({tag, "_hold"}, cpu_hold, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, error, 0);
        chk({tag, "_words"}, words_wr, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        tick(2);
        check_reset("rst");
        reset = 1'b0;
        tick();
        chk("idle_rdy", in_ready, 0);

        // basic two-word image with exact write latency
        clr();
        pulse_start();
        chk("t1_hold", cpu_hold, 1);
        chk("t1_rdy", in_ready, 1);
        send(8'h00, 0);
        send(8'h02, 0);
        send(8'h20, 0);
        send(8'h08, 0);
        send(8'h00, 0);
        chk("t1_nowen", wr_en, 0);
        send(8'h05, 0);
        chk("t1_wen0", wr_en, 1);
        chk("t1_addr0", wr_addr, 0);
        chk("t1_data0", wr_data, 32'h20080005);
        chk("t1_rdy_wr", in_ready, 0);
        send(8'hAC, 0);
        send(8'h08, 0);
        send(8'h00, 0);
        send(8'h04, 0);
        chk("t1_wen1", wr_en, 1);
        chk("t1_addr1", wr_addr, 1);
        chk("t1_data1", wr_data, 32'hAC080004);
        chk("t1_done_early", done, 0);
        tick();
        chk("t1_wen_off", wr_en, 0);
        chk("t1_addr_hold", wr_addr, 1);
        chk("t1_data_hold", wr_data, 32'hAC080004);
        check_img("t1");

        // empty image
        clr();
        pulse_start();
        chk("t2_words_clr", words_wr, 0);
        chk("t2_done_clr", done, 0);
        send(8'h00, 0);
        chk("t2_done_mid", done, 0);
        send(8'h00, 0);
        chk("t2_done", done, 1);
        chk("t2_hold", cpu_hold, 0);
        chk("t2_words", words_wr, 0);
        tick(2);
        chk("t2_npulse", wa.size(), 0);

        // oversize header 1026
        clr();
        pulse_start();
        send(8'h04, 0);
        send(8'h02, 0);
        chk("t3_err", error, 1);
        chk("t3_done", done, 0);
        chk("t3_hold", cpu_hold, 0);
        in_valid = 1'b1;
        tick(3);
        chk("t3_rdy", in_ready, 0);
        chk("t3_nacc", nacc, 2);
        in_valid = 1'b0;
        chk("t3_npulse", wa.size(), 0);

        // header exactly DEPTH is legal
        pulse_start();
        chk("t3b_err_clr", error, 0);
        send(8'h04, 0);
        send(8'h01, 0);
        chk("t3b_err", error, 0);
        chk("t3b_rdy", in_ready, 1);
        chk("t3b_hold", cpu_hold, 1);

        // reset mid-load, then reload
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clr();
        pulse_start();
        for (int i = 0; i < 7; i++) send(img[i], 0);
        reset = 1'b1;
        tick();
        check_reset("t5_rst");
        reset = 1'b0;
        tick(2);
        chk("t5_npulse", wa.size(), 1);
        chk("t5_a0", wa.size() > 0 ? wa[0] : 'x, 0);
        clr();
        pulse_start();
        send_img(0, -1);
        check_img("t5");

        // random in_valid gaps
        clr();
        pulse_start();
        send_img(1, -1);
        check_img("t4");

        // start during DATA is ignored; start in DONE restarts
        clr();
        pulse_start();
        send_img(0, 4);
        check_img("t6");
        pulse_start();
        chk("t6_words", words_wr, 0);
        chk("t6_addr", wr_addr, 0);
        chk("t6_hold", cpu_hold, 1);
        chk("t6_done", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
